ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Single-port RAM front end sitting directly downstream of the memory arbiter/coherence controller.
//  Consumes ramaddr/ramREN/ramWEN/ramstore and returns ramload plus ramstate (FREE/BUSY/ACCESS/ERROR).
//  Models a fixed, parameterised access latency in front of a word-addressed backing array.
//  Restarts the access whenever the request changes mid-flight.
// PARAMETERS
//  LAT     2     BUSY cycles before ACCESS (0..15); 0 = ACCESS the cycle after the request is sampled
//  DEPTH   4096  backing array size in 32-bit words (power of 2)
// PORTS
//  CLK        in   1   system clock, rising edge
//  nRST       in   1   asynchronous active-low reset
//  ramaddr    in   32  byte address (word_t)
//  ramREN     in   1   read request, level, held until ACCESS
//  ramWEN     in   1   write request, level, held until ACCESS
//  ramstore   in   32  write data, must be stable while ramWEN=1
//  ramload    out  32  read data, valid only while ramstate==ACCESS on a read
//  ramstate   out  2   ramstate_t: FREE, BUSY, ACCESS, ERROR
// BEHAVIOUR
//  Reset: state IDLE, count 0, latched addr/op 0, ramstate=FREE, ramload=0. Array contents are not cleared.
//  Reset mid-access aborts the access; no write occurs.
//  FSM IDLE/WAIT/ACC/ERR; ramstate is registered: IDLE->FREE, WAIT->BUSY, ACC->ACCESS, ERR->ERROR.
//  IDLE: on a valid request (exactly one of REN/WEN), latch addr+op and load count=LAT.
//   LAT>0 -> WAIT; LAT==0 -> ACC.
//  WAIT: count-- per cycle; at count==1 -> ACC. Request dropped -> IDLE, no side effects.
//   Addr or op differs from latched value -> relatch, reload count=LAT, stay WAIT (or go ACC if LAT==0).
//  ACC: one cycle.
//   Read: ramload = array[latched idx], issued via sync read at the edge entering ACC.
//   Write: array[idx] <= ramstore at the edge leaving ACC.
//   Next state is evaluated as from IDLE, so a held or changed request starts a new access immediately (back-to-back).
//  ERR conditions: REN&&WEN simultaneously, addr[1:0]!=0, or word index >= DEPTH.
//   Enter ERR for one cycle instead of WAIT/ACC; no array write. Next state is evaluated as from IDLE.
//  Latency: request first sampled at edge k -> ACCESS during cycle k+LAT+1 (relative to cycle k).
//  Index = ramaddr[$clog2(DEPTH)+1:2]; upper bits must be 0, otherwise ERR.
//  ramload = 0 outside ACC-on-read.
// CONFIGURATION
//  RAM_STATS_EN defined:
//   Adds outputs rd_count, wr_count, stall_count (32 bits each, reset 0, saturating).
//   rd_count/wr_count increment on each completed ACC read/write; stall_count increments each WAIT cycle.
//  RAM_STATS_EN undefined: these ports and counters do not exist; no other behavioural change.
// STRUCTURE
//  cpu_types_pkg: ramstate_t (existing), word_t; add ram_op_t {RAM_RD, RAM_WR} and the RAM_LAT_DEFAULT constant.
//  Sub-module ram_array: DEPTH x 32, one synchronous read port, one synchronous write port, no reset.
//  The FSM, counter and error decode live in ram_access_ctrl.
// TESTING
//  1. LAT=2: write 0x0000_0040 <= 0xDEADBEEF, then read 0x40.
//     -> BUSY,BUSY,ACCESS for each; ramload=0xDEADBEEF during the read ACCESS.
//  2. LAT=2: REN held while addr goes 0x40 -> 0x44 after one BUSY cycle.
//     -> BUSY count restarts; ACCESS arrives 3 cycles after the change with array[0x44>>2].
//  3. REN held after ACCESS with addr stepped 0x40 -> 0x44 (block fill).
//     -> second ACCESS LAT+1 cycles later, no FREE gap.
//  4. REN=WEN=1, or addr=0x42, or addr=DEPTH*4.
//     -> ERROR each cycle; array unchanged (verify by later read).
//  5. nRST pulsed low during BUSY of a write to 0x80.
//     -> ramstate=FREE immediately; array[0x80>>2] keeps its prior value.
//  6. LAT=0 with RAM_STATS_EN: 3 reads, 2 writes.
//     -> ACCESS every other cycle; rd_count=3, wr_count=2, stall_count=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM state, RAM op and controller FSM types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic {RAM_RD, RAM_WR} ram_op_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} ram_ctrl_state_t;

  localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - DEPTH x 32 backing store, one sync read port and one sync write port, no reset
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     CLK,
  input  logic                     ren,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output word_t                    rdata,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  word_t                    wdata
);

  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - fixed-latency RAM front end (IDLE/WAIT/ACC/ERR FSM)
// Optional access statistics outputs under RAM_STATS_EN.
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT   = RAM_LAT_DEFAULT,
  parameter int DEPTH = 4096
) (
  input  logic      CLK,
  input  logic      nRST,
  input  word_t     ramaddr,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
`ifdef RAM_STATS_EN
  ,
  output word_t     rd_count,
  output word_t     wr_count,
  output word_t     stall_count
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LATV = 4'(LAT);

  ram_ctrl_state_t state, state_n;
  logic [3:0]      count, count_n;
  word_t           lat_addr, lat_addr_n;
  ram_op_t         lat_op, lat_op_n;

  logic            req_any, req_err, changed, start;
  ram_op_t         req_op;

  logic            arr_ren, arr_wen;
  logic [IW-1:0]   arr_raddr;
  word_t           arr_rdata;

  assign req_any = ramREN | ramWEN;
  assign req_op  = ramWEN ? RAM_WR : RAM_RD;
  // Upper address bits non-zero covers every word index >= DEPTH.
  assign req_err = (ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) ||
                   ((ramaddr >> (IW + 2)) != '0);
  assign changed = (ramaddr != lat_addr) || (req_op != lat_op) || (ramREN && ramWEN);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      count    <= '0;
      lat_addr <= '0;
      lat_op   <= RAM_RD;
    end else begin
      state    <= state_n;
      count    <= count_n;
      lat_addr <= lat_addr_n;
      lat_op   <= lat_op_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    lat_addr_n = lat_addr;
    lat_op_n   = lat_op;
    start      = 1'b0;
    case (state)
      WAIT: begin
        if (!req_any)          state_n = IDLE;
        else if (changed)      start   = 1'b1;
        else if (count == 4'd1) state_n = ACC;
        else                   count_n = count - 4'd1;
      end
      default: start = 1'b1;
    endcase
    // ACC and ERR fall through to the same decision as IDLE, giving back-to-back accesses.
    if (start) begin
      if (!req_any) begin
        state_n = IDLE;
      end else if (req_err) begin
        state_n = ERR;
      end else begin
        lat_addr_n = ramaddr;
        lat_op_n   = req_op;
        count_n    = LATV;
        state_n    = (LAT == 0) ? ACC : WAIT;
      end
    end
  end

  always_comb begin
    ramstate  = FREE;
    case (state)
      IDLE:    ramstate = FREE;
      WAIT:    ramstate = BUSY;
      ACC:     ramstate = ACCESS;
      default: ramstate = ERROR;
    endcase
    arr_ren   = (state_n == ACC) && (lat_op_n == RAM_RD);
    arr_raddr = lat_addr_n[IW+1:2];
    arr_wen   = (state == ACC) && (lat_op == RAM_WR);
    ramload   = ((state == ACC) && (lat_op == RAM_RD)) ? arr_rdata : '0;
  end

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .ren   (arr_ren),
    .raddr (arr_raddr),
    .rdata (arr_rdata),
    .wen   (arr_wen),
    .waddr (lat_addr[IW+1:2]),
    .wdata (ramstore)
  );

`ifdef RAM_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_count    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if ((state == ACC) && (lat_op == RAM_RD) && (rd_count != '1)) rd_count <= rd_count + 32'd1;
      if ((state == ACC) && (lat_op == RAM_WR) && (wr_count != '1)) wr_count <= wr_count + 32'd1;
      if ((state == WAIT) && (stall_count != '1)) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl (LAT=2 and LAT=0 instances)
module tb_ram_access_ctrl;
  import cpu_types_pkg::*;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_load;
  } txn_t;

  logic      CLK = 1'b0;
  logic      nRST;
  word_t     ramaddr, ramstore, ramload;
  logic      ramREN, ramWEN;
  ramstate_t ramstate;
  word_t     ramaddr0, ramstore0, ramload0;
  logic      ramREN0, ramWEN0;
  ramstate_t ramstate0;
`ifdef RAM_STATS_EN
  word_t     rd_cnt, wr_cnt, st_cnt, rd_cnt0, wr_cnt0, st_cnt0;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] sb[$];
  txn_t t2[13];
  txn_t t0[5];

  always #5 CLK = ~CLK;

  ram_access_ctrl #(.LAT(2), .DEPTH(4096)) dut (
    .CLK(CLK), .nRST(nRST), .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef RAM_STATS_EN
    , .rd_count(rd_cnt), .wr_count(wr_cnt), .stall_count(st_cnt)
`endif
  );

  ram_access_ctrl #(.LAT(0), .DEPTH(4096)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramaddr(ramaddr0), .ramREN(ramREN0), .ramWEN(ramWEN0),
    .ramstore(ramstore0), .ramload(ramload0), .ramstate(ramstate0)
`ifdef RAM_STATS_EN
    , .rd_count(rd_cnt0), .wr_count(wr_cnt0), .stall_count(st_cnt0)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit sel, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      ramREN0 = ren; ramWEN0 = wen; ramaddr0 = addr; ramstore0 = data;
    end else begin
      ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = data;
    end
  endtask

  task automatic drop(input bit sel);
    if (sel) begin ramREN0 = 1'b0; ramWEN0 = 1'b0; end
    else begin ramREN = 1'b0; ramWEN = 1'b0; end
  endtask

  function automatic logic [31:0] st(input bit sel);
    return sel ? 32'(ramstate0) : 32'(ramstate);
  endfunction

  function automatic logic [31:0] ld(input bit sel);
    return sel ? ramload0 : ramload;
  endfunction

  task automatic pop_check(input bit sel, input string name);
    logic [31:0] e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty at ACCESS", name);
    end else begin
      e = sb.pop_front();
      check(name, ld(sel), e);
    end
  endtask

  task automatic run_txn(input bit sel, input int lat, input txn_t t, input string name);
    drive(sel, t.ren, t.wen, t.addr, t.data);
    if (t.ren && !t.wen && !t.err) sb.push_back(t.exp_load);
    step();
    if (t.err) begin
      check({name, " error"}, st(sel), 32'(ERROR));
    end else begin
      for (int i = 0; i < lat; i++) begin
        check({name, " busy"}, st(sel), 32'(BUSY));
        step();
      end
      check({name, " access"}, st(sel), 32'(ACCESS));
      if (t.ren) pop_check(sel, {name, " load"});
      else check({name, " load zero on write"}, ld(sel), 32'h0);
    end
    drop(sel);
    step();
    check({name, " free"}, st(sel), 32'(FREE));
    check({name, " load idle"}, ld(sel), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t2[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b0, 32'h0};
    t2[1]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0};
    t2[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
    t2[3]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0, 32'h0};
    t2[4]  = '{1'b0, 1'b1, 32'h0000_0080, 32'h1111_1111, 1'b0, 32'h0};
    t2[5]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b0, 32'h1234_5678};
    t2[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0000};
    t2[7]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 1'b1, 32'h0};
    t2[8]  = '{1'b0, 1'b1, 32'h0000_0042, 32'hBAD0_BAD0, 1'b1, 32'h0};
    t2[9]  = '{1'b0, 1'b1, 32'h0000_4000, 32'hBAD1_BAD1, 1'b1, 32'h0};
    t2[10] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
    t2[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0000};
    t2[12] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         1'b0, 32'h1111_1111};
    t0[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_0001, 1'b0, 32'h0};
    t0[1]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_0002, 1'b0, 32'h0};
    t0[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_0001};
    t0[3]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hCAFE_0002};
    t0[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_0001};

    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("reset ramstate", st(1'b0), 32'(FREE));
    check("reset ramload", ld(1'b0), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    check("idle ramstate", st(1'b0), 32'(FREE));

    for (int i = 0; i < 13; i++) run_txn(1'b0, 2, t2[i], $sformatf("lat2 txn%0d", i));

    // request changes one BUSY cycle in: latency restarts
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    step();
    check("restart busy0", st(1'b0), 32'(BUSY));
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
    sb.push_back(32'h1234_5678);
    step();
    check("restart busy1", st(1'b0), 32'(BUSY));
    step();
    check("restart busy2", st(1'b0), 32'(BUSY));
    step();
    check("restart access", st(1'b0), 32'(ACCESS));
    pop_check(1'b0, "restart load");
    drop(1'b0);
    step();
    check("restart free", st(1'b0), 32'(FREE));

    // block fill: held REN with stepped address, no FREE gap
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    sb.push_back(32'hDEAD_BEEF);
    repeat (2) begin step(); check("fill busy a", st(1'b0), 32'(BUSY)); end
    step();
    check("fill access a", st(1'b0), 32'(ACCESS));
    pop_check(1'b0, "fill load a");
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
    sb.push_back(32'h1234_5678);
    repeat (2) begin step(); check("fill busy b", st(1'b0), 32'(BUSY)); end
    step();
    check("fill access b", st(1'b0), 32'(ACCESS));
    pop_check(1'b0, "fill load b");
    drop(1'b0);
    step();
    check("fill free", st(1'b0), 32'(FREE));

    // held erroneous requests stay in ERROR every cycle
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF);
    repeat (3) begin step(); check("held both error", st(1'b0), 32'(ERROR)); end
    drive(1'b0, 1'b0, 1'b1, 32'h4000, 32'hFFFF_FFFF);
    repeat (2) begin step(); check("held range error", st(1'b0), 32'(ERROR)); end
    drop(1'b0);
    step();
    check("held error free", st(1'b0), 32'(FREE));
    run_txn(1'b0, 2, t2[10], "after error 0x40");
    run_txn(1'b0, 2, t2[11], "after error 0x00");

    // reset in the middle of a write aborts it
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'h2222_2222);
    step();
    check("abort busy", st(1'b0), 32'(BUSY));
    nRST = 1'b0;
    #1;
    check("abort free immediate", st(1'b0), 32'(FREE));
    @(negedge CLK);
    drop(1'b0);
    nRST = 1'b1;
    step();
    check("abort free after", st(1'b0), 32'(FREE));
    run_txn(1'b0, 2, t2[12], "abort keeps 0x80");

    // LAT=0 instance: ACCESS the cycle after the request
    for (int i = 0; i < 5; i++) run_txn(1'b1, 0, t0[i], $sformatf("lat0 txn%0d", i));
`ifdef RAM_STATS_EN
    check("lat0 rd_count", rd_cnt0, 32'd3);
    check("lat0 wr_count", wr_cnt0, 32'd2);
    check("lat0 stall_count", st_cnt0, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
